// File: rtl/vm_pkg.sv
// Shared definitions for the vector machine control path: FSM state encodings
// and accumulation mode codes.
package vm_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        SQUARE = 3'd3,
        SUM    = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [1:0] MODE_SUM   = 2'b00;
    localparam logic [1:0] MODE_SUMSQ = 2'b01;
    localparam logic [1:0] MODE_COUNT = 2'b10;

endpackage

// File: rtl/Register_Unit.sv
// Generic load-enabled register with asynchronous active-high reset to zero.
// Ports: clk, reset, load (capture d this edge), d (next value), q (held value).
module Register_Unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/vector_walk_ctrl.sv
// Linked-list walker for the vector machine. Fetches each node (next pointer on
// port 1, value on port 2) and sequences the datapath enables for SUM, SUMSQ or
// COUNT accumulation, with node counting and loop-limit protection.
// Ports: clk, reset (async, active-high); start/mode/head_addr request inputs;
// rd_data1/rd_data2 memory read data; rd_addr1/rd_addr2/rd_en memory reads;
// clr_acc/store_d/e_square/e_sum datapath enables; busy/done handshake;
// err_loop traversal-limit flag; node_count nodes processed.
// Every output is a register that holds the decode of the state it accompanies.
module vector_walk_ctrl
    import vm_pkg::*;
#(
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned WORD_W    = 24,
    parameter int unsigned MAX_NODES = 256,
    parameter int unsigned CNT_W     = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] head_addr,
    input  logic [WORD_W-1:0] rd_data1,
    input  logic [WORD_W-1:0] rd_data2,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic [ADDR_W-1:0] rd_addr2,
    output logic              rd_en,
    output logic              clr_acc,
    output logic              store_d,
    output logic              e_square,
    output logic              e_sum,
    output logic              busy,
    output logic              done,
    output logic              err_loop,
    output logic [CNT_W-1:0]  node_count
);

    state_t            state;
    logic [1:0]        mode_q;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] next_ptr;
    logic              load_next;
    logic              accum_mode;
    logic              unused_bits;

    // Value word belongs to the datapath; upper pointer-word bits are not address.
    assign unused_bits = ^{rd_data2, rd_data1[WORD_W-1:ADDR_W]};

    // Mode 11 falls out as COUNT because only SUM/SUMSQ accumulate.
    assign accum_mode = (mode_q == MODE_SUM) || (mode_q == MODE_SUMSQ);
    assign load_next  = (state == LOAD);

    // Next-pointer register, captured while the fetched node data is valid.
    Register_Unit #(.WIDTH(ADDR_W)) u_next_ptr (
        .clk   (clk),
        .reset (reset),
        .load  (load_next),
        .d     (rd_data1[ADDR_W-1:0]),
        .q     (next_ptr)
    );

    // Walk sequencer. IDLE with busy set is the accumulator-clear cycle that
    // follows start accept; outputs for the state being entered are loaded on
    // the same edge so they line up with that state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            mode_q     <= MODE_SUM;
            cur        <= '0;
            rd_addr1   <= '0;
            rd_addr2   <= '0;
            rd_en      <= 1'b0;
            clr_acc    <= 1'b0;
            store_d    <= 1'b0;
            e_square   <= 1'b0;
            e_sum      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_loop   <= 1'b0;
            node_count <= '0;
        end else begin
            rd_en    <= 1'b0;
            clr_acc  <= 1'b0;
            store_d  <= 1'b0;
            e_square <= 1'b0;
            e_sum    <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (busy) begin
                        state    <= FETCH;
                        rd_en    <= 1'b1;
                        rd_addr1 <= cur;
                        rd_addr2 <= cur + ADDR_W'(1);
                    end else if (start) begin
                        mode_q     <= mode;
                        cur        <= head_addr;
                        clr_acc    <= 1'b1;
                        busy       <= 1'b1;
                        node_count <= '0;
                        err_loop   <= 1'b0;
                    end
                end
                FETCH: begin
                    state   <= LOAD;
                    store_d <= accum_mode;
                end
                LOAD: begin
                    node_count <= node_count + CNT_W'(1);
                    if (mode_q == MODE_SUMSQ) begin
                        state    <= SQUARE;
                        e_square <= 1'b1;
                    end else begin
                        state <= SUM;
                        e_sum <= accum_mode;
                    end
                end
                SQUARE: begin
                    state <= SUM;
                    e_sum <= 1'b1;
                end
                SUM: begin
                    if (next_ptr == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (node_count == CNT_W'(MAX_NODES)) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        err_loop <= 1'b1;
                    end else begin
                        state    <= FETCH;
                        cur      <= next_ptr;
                        rd_en    <= 1'b1;
                        rd_addr1 <= next_ptr;
                        rd_addr2 <= next_ptr + ADDR_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_walk_ctrl.sv
// Self-checking bench for vector_walk_ctrl: two instances (default limit and
// MAX_NODES=4) over a shared word memory with one-cycle read latency.
module tb_vector_walk_ctrl;

    typedef struct {
        int         sel;
        int         list;
        logic [1:0] mode;
        logic [8:0] head;
        bit         repulse;
        int         exp_done;
        int         exp_cnt;
        bit         exp_err;
        int         exp_st;
        int         exp_sq;
        int         exp_sum;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_s  [2];
    logic [1:0]  mode_s   [2];
    logic [8:0]  head_s   [2];
    logic [23:0] rd1      [2];
    logic [23:0] rd2      [2];
    logic [8:0]  rd_addr1 [2];
    logic [8:0]  rd_addr2 [2];
    logic        rd_en    [2];
    logic        clr_acc  [2];
    logic        store_d  [2];
    logic        e_square [2];
    logic        e_sum    [2];
    logic        busy     [2];
    logic        done     [2];
    logic        err_loop [2];
    logic [8:0]  node_count [2];

    logic [23:0] mem [512];
    vec_t        sb [$];
    vec_t        tbl [7];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    vector_walk_ctrl dut (
        .clk(clk), .reset(reset), .start(start_s[0]), .mode(mode_s[0]),
        .head_addr(head_s[0]), .rd_data1(rd1[0]), .rd_data2(rd2[0]),
        .rd_addr1(rd_addr1[0]), .rd_addr2(rd_addr2[0]), .rd_en(rd_en[0]),
        .clr_acc(clr_acc[0]), .store_d(store_d[0]), .e_square(e_square[0]),
        .e_sum(e_sum[0]), .busy(busy[0]), .done(done[0]),
        .err_loop(err_loop[0]), .node_count(node_count[0])
    );

    vector_walk_ctrl #(.MAX_NODES(4)) dut4 (
        .clk(clk), .reset(reset), .start(start_s[1]), .mode(mode_s[1]),
        .head_addr(head_s[1]), .rd_data1(rd1[1]), .rd_data2(rd2[1]),
        .rd_addr1(rd_addr1[1]), .rd_addr2(rd_addr2[1]), .rd_en(rd_en[1]),
        .clr_acc(clr_acc[1]), .store_d(store_d[1]), .e_square(e_square[1]),
        .e_sum(e_sum[1]), .busy(busy[1]), .done(done[1]),
        .err_loop(err_loop[1]), .node_count(node_count[1])
    );

    // Memory model: data returns the cycle after rd_en.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rd_en[i]) begin
                rd1[i] <= mem[rd_addr1[i]];
                rd2[i] <= mem[rd_addr2[i]];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load_mem(input int list);
        for (int i = 0; i < 512; i++) mem[i] = 24'h0;
        case (list)
            0: begin mem[9'h010] = 24'h0; mem[9'h011] = 24'd5; end
            1: begin
                mem[9'h000] = 24'h5A0020; mem[9'h001] = 24'd1;
                mem[9'h020] = 24'h000040; mem[9'h021] = 24'd2;
                mem[9'h040] = 24'hFFFE00; mem[9'h041] = 24'd3;
            end
            2: begin
                mem[9'h010] = 24'h020; mem[9'h011] = 24'd7;
                mem[9'h020] = 24'h010; mem[9'h021] = 24'd9;
            end
            3: begin
                mem[9'h100] = 24'h104; mem[9'h104] = 24'h108;
                mem[9'h108] = 24'h10C; mem[9'h10C] = 24'h110;
                mem[9'h110] = 24'h000;
                for (int i = 0; i < 5; i++) mem[9'h101 + 4 * i] = 24'(i + 10);
            end
            default: begin mem[9'h1FF] = 24'h0; mem[9'h000] = 24'd4; end
        endcase
    endtask

    // Run one table row: expectations queued at start, checked at done.
    task automatic run_vec(input vec_t v);
        logic [8:0] eq [$];
        logic [8:0] a;
        logic [8:0] nxt;
        logic [8:0] a2;
        vec_t       e;
        int         nst = 0;
        int         nsq = 0;
        int         nsum = 0;
        bit         got = 0;
        int         lim;
        load_mem(v.list);
        lim = (v.sel == 1) ? 4 : 256;
        a = v.head;
        for (int n = 0; n < lim; n++) begin
            eq.push_back(a);
            nxt = mem[a][8:0];
            if (nxt == 9'h0) break;
            a = nxt;
        end
        @(negedge clk);
        start_s[v.sel] = 1'b1;
        mode_s[v.sel]  = v.mode;
        head_s[v.sel]  = v.head;
        sb.push_back(v);
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            start_s[v.sel] = v.repulse && (k == 6);
            mode_s[v.sel]  = ~mode_s[v.sel];
            head_s[v.sel]  = head_s[v.sel] + 9'h33;
            if (k == 0) begin
                chk("clr_acc_first", 32'(clr_acc[v.sel]), 32'd1);
                chk("busy_first", 32'(busy[v.sel]), 32'd1);
            end
            if (rd_en[v.sel]) begin
                if (eq.size() == 0) begin
                    chk("rd_en_extra", 32'd1, 32'd0);
                end else begin
                    a  = eq.pop_front();
                    a2 = a + 9'd1;
                    chk("rd_addr1", 32'(rd_addr1[v.sel]), 32'(a));
                    chk("rd_addr2", 32'(rd_addr2[v.sel]), 32'(a2));
                end
            end
            nst  += int'(store_d[v.sel]);
            nsq  += int'(e_square[v.sel]);
            nsum += int'(e_sum[v.sel]);
            if (done[v.sel]) begin
                got = 1;
                e = sb.pop_front();
                chk("done_cycle", 32'(k), 32'(e.exp_done));
                chk("node_count", 32'(node_count[v.sel]), 32'(e.exp_cnt));
                chk("err_loop", 32'(err_loop[v.sel]), 32'(e.exp_err));
                chk("store_d_pulses", 32'(nst), 32'(e.exp_st));
                chk("e_square_pulses", 32'(nsq), 32'(e.exp_sq));
                chk("e_sum_pulses", 32'(nsum), 32'(e.exp_sum));
                chk("rd_missing", 32'(eq.size()), 32'd0);
                break;
            end
        end
        start_s[v.sel] = 1'b0;
        if (!got) begin
            chk("done_timeout", 32'd0, 32'd1);
            void'(sb.pop_front());
        end
        @(negedge clk);
        chk("busy_after_done", 32'(busy[v.sel]), 32'd0);
        chk("done_one_cycle", 32'(done[v.sel]), 32'd0);
        chk("node_count_held", 32'(node_count[v.sel]), 32'(v.exp_cnt));
        chk("err_loop_held", 32'(err_loop[v.sel]), 32'(v.exp_err));
    endtask

    initial begin
        logic [6:0] exp_tr [7];
        logic [6:0] act_tr;
        tbl[0] = '{0, 0, 2'b01, 9'h010, 1'b0,  5, 1, 1'b0, 1, 1, 1};
        tbl[1] = '{0, 1, 2'b01, 9'h000, 1'b0, 13, 3, 1'b0, 3, 3, 3};
        tbl[2] = '{1, 2, 2'b00, 9'h010, 1'b0, 13, 4, 1'b1, 4, 0, 4};
        tbl[3] = '{0, 3, 2'b10, 9'h100, 1'b1, 16, 5, 1'b0, 0, 0, 0};
        tbl[4] = '{0, 3, 2'b11, 9'h100, 1'b0, 16, 5, 1'b0, 0, 0, 0};
        tbl[5] = '{0, 1, 2'b00, 9'h000, 1'b0, 10, 3, 1'b0, 3, 0, 3};
        tbl[6] = '{0, 6, 2'b01, 9'h1FF, 1'b0,  5, 1, 1'b0, 1, 1, 1};
        // {clr_acc, rd_en, store_d, e_square, e_sum, done, busy} per cycle
        exp_tr[0] = 7'b1000001;
        exp_tr[1] = 7'b0100001;
        exp_tr[2] = 7'b0010001;
        exp_tr[3] = 7'b0001001;
        exp_tr[4] = 7'b0000101;
        exp_tr[5] = 7'b0000011;
        exp_tr[6] = 7'b0000000;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0;
            mode_s[i]  = 2'b00;
            head_s[i]  = 9'h0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_busy", 32'(busy[i]), 32'd0);
            chk("reset_rd_addr1", 32'(rd_addr1[i]), 32'd0);
            chk("reset_node_count", 32'(node_count[i]), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 6; r++) run_vec(tbl[r]);

        // Cycle-exact single node, with start pulsed in the done cycle
        load_mem(0);
        @(negedge clk);
        start_s[0] = 1'b1; mode_s[0] = 2'b01; head_s[0] = 9'h010;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            start_s[0] = (k == 5);
            act_tr = {clr_acc[0], rd_en[0], store_d[0], e_square[0], e_sum[0], done[0], busy[0]};
            if (k < 7) chk($sformatf("trace_c%0d", k), 32'(act_tr), 32'(exp_tr[k]));
            else chk("start_in_done_ignored", 32'(busy[0]), 32'd0);
            if (k == 1) begin
                chk("trace_addr1", 32'(rd_addr1[0]), 32'h010);
                chk("trace_addr2", 32'(rd_addr2[0]), 32'h011);
            end
        end

        // Asynchronous reset while in SQUARE
        @(negedge clk);
        start_s[0] = 1'b1; mode_s[0] = 2'b01; head_s[0] = 9'h010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start_s[0] = 1'b0;
        end
        chk("square_before_reset", 32'(e_square[0]), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("reset_mid_outputs", 32'({rd_en[0], clr_acc[0], store_d[0], e_square[0], e_sum[0],
                                      busy[0], done[0], err_loop[0]}), 32'd0);
        chk("reset_mid_addr", 32'({rd_addr1[0], rd_addr2[0]}), 32'd0);
        chk("reset_mid_count", 32'(node_count[0]), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Head at top of memory: port-2 address wraps to 0
        run_vec(tbl[6]);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
